regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
  - Requester 0: ALU/execute writeback.
  - Requester 1: load/memory writeback.
- Uses valid/ready handshakes and round-robin arbitration.
- Keeps a 32-entry pending-write scoreboard so issue logic can stall on RAW hazards.
- Sits between pipeline writeback stages and the register file write channel (wr_ena/wr_addr/wr_data).

Parameters:
- XLEN, 32, data width of register file words.
- NUM_REGS, 32, architectural registers; x0 hardwired zero.
- ADDR_W, 5, register address width, equal to log2(NUM_REGS).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on clk rising edge.
- req0_valid  input  1  requester 0 has a writeback.
- req0_ready  output  1  requester 0 writeback accepted this cycle.
- req0_addr  input  ADDR_W  requester 0 destination register.
- req0_data  input  XLEN  requester 0 write data.
- req1_valid  input  1  requester 1 has a writeback.
- req1_ready  output  1  requester 1 writeback accepted this cycle.
- req1_addr  input  ADDR_W  requester 1 destination register.
- req1_data  input  XLEN  requester 1 write data.
- iss_valid  input  1  an instruction issues that will write iss_addr.
- iss_addr  input  ADDR_W  destination register of the issuing instruction.
- chk_addr0  input  ADDR_W  source register 0 to hazard-check.
- chk_addr1  input  ADDR_W  source register 1 to hazard-check.
- busy0  output  1  chk_addr0 has a pending write (combinational).
- busy1  output  1  chk_addr1 has a pending write (combinational).
- wr_ena  output  1  register file write enable (registered).
- wr_addr  output  ADDR_W  register file write address (registered).
- wr_data  output  XLEN  register file write data (registered).
- err_double_issue  output  1  sticky flag: iss to an already-busy register.

Behaviour:
- Reset (rst==0 at an edge) clears:
  - wr_ena, wr_addr, wr_data = 0;
  - all scoreboard bits = 0;
  - err_double_issue = 0;
  - round-robin pointer = 0 (requester 0 favoured first).
- Reset mid-operation discards any registered write; no write reaches the register file on the next cycle.
- Arbitration is combinational on valids:
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester selected by the pointer gets ready=1, the other ready=0.
  - Neither valid: both ready=0.
  - ready never depends on ready.
- Pointer update on each accepted handshake: pointer = the non-granted index. The pointer holds when idle or when a single requester is serviced.
- Handshake = valid && ready. Latency is 1 cycle: on the next cycle, wr_ena=1 and wr_addr/wr_data equal the granted request.
- Without a handshake, wr_ena=0 next cycle; wr_addr/wr_data hold their previous values.
- Writes to x0: handshake is accepted, but wr_ena stays 0 and the scoreboard is unaffected.
- Requesters must hold addr/data stable while valid && !ready.
- Scoreboard set: busy[iss_addr] is set at the edge where iss_valid=1 and iss_addr!=0.
- Scoreboard clear: busy[wr_addr] is cleared at the edge where wr_ena=1, i.e. the edge that commits the register file write.
- Simultaneous set and clear on the same register: set wins (a new producer supersedes).
- busy0/busy1 = scoreboard[chk_addrN]; always 0 for chk_addrN==0.
- iss_valid to a register already busy and not being cleared that edge: err_double_issue becomes 1 and stays 1 until reset; the bit remains set.

Optional Feature:
- Macro WB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 1 (load) always wins when both are valid; pointer logic removed.
- Undefined: round-robin as above.

Decomposition:
- Package regfile_pkg holds:
  - constants XLEN=32, NUM_REGS=32, ADDR_W=5;
  - typedefs reg_addr_t (logic [ADDR_W-1:0]) and word_t (logic [XLEN-1:0]).
- One sub-module: wb_rr_arbiter (2-way grant plus pointer register, fixed-priority variant under the macro).
- Scoreboard set/clear masks use the existing decoder_5_to_32.

Test Plan:
- Reset, then req0 valid, addr=5, data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle wr_ena=1, wr_addr=5, wr_data=0xDEADBEEF.
- Both valid continuously for 4 cycles (addr 1 / addr 2) -> grants alternate 0,1,0,1; with WB_ARB_FIXED_PRIO_EN, grants are 1,1,1,1.
- iss_valid addr=7; chk_addr0=7 -> busy0=1; req1 writes x7 -> busy0 stays 1 through the wr_ena cycle and reads 0 the cycle after.
- req0 to x0, data=0x1234 -> req0_ready=1; wr_ena stays 0; busy for chk_addr=0 is always 0.
- iss_valid x3 twice without writeback -> err_double_issue=1 and stays 1 until rst=0; the same-edge iss x3 and wr_ena x3 case leaves busy=1 with no error.
- rst=0 for one cycle while a handshake is in flight -> wr_ena=0 next cycle; all busy outputs 0; pointer back to requester 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and types for the register file writeback path
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  // Round-robin pointer value: which requester is favoured when both are valid.
  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_idx_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester handshakes and register file write channel
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
();

  logic      req0_valid;
  logic      req0_ready;
  reg_addr_t req0_addr;
  word_t     req0_data;

  logic      req1_valid;
  logic      req1_ready;
  reg_addr_t req1_addr;
  word_t     req1_data;

  logic      wr_ena;
  reg_addr_t wr_addr;
  word_t     wr_data;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wr_ena, wr_addr, wr_data
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wr_ena, wr_addr, wr_data
  );

endinterface

// File: rtl/decoder_5_to_32.sv
// rtl/decoder_5_to_32.sv - enabled 5-bit to one-hot 32-bit decoder
module decoder_5_to_32 (
  input  logic        en,
  input  logic [4:0]  sel,
  output logic [31:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - 2-way writeback grant; WB_ARB_FIXED_PRIO_EN selects fixed priority (load wins)
module wb_rr_arbiter
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

`ifdef WB_ARB_FIXED_PRIO_EN

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    grant1 = valid1;
    grant0 = valid0 && !valid1;
  end

`else

  req_idx_e ptr_q;
  req_idx_e ptr_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= REQ_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Grants follow valids only; the pointer moves only on a contested cycle.
  always_comb begin
    ptr_d  = ptr_q;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (valid0 && valid1) begin
      if (ptr_q == REQ_ALU) begin
        grant0 = 1'b1;
        ptr_d  = REQ_LOAD;
      end else begin
        grant1 = 1'b1;
        ptr_d  = REQ_ALU;
      end
    end else begin
      grant0 = valid0;
      grant1 = valid1;
    end
  end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register file write port between ALU and load writeback
// and tracks pending writes for RAW stalls; WB_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  wb,
  input  logic                 iss_valid,
  input  reg_addr_t            iss_addr,
  input  reg_addr_t            chk_addr0,
  input  reg_addr_t            chk_addr1,
  output logic                 busy0,
  output logic                 busy1,
  output logic                 err_double_issue
);

  logic      grant0;
  logic      grant1;
  logic      hs;
  reg_addr_t sel_addr;
  word_t     sel_data;

  logic      wr_ena_q;
  reg_addr_t wr_addr_q;
  word_t     wr_data_q;

  logic [NUM_REGS-1:0] sb_q;
  logic [NUM_REGS-1:0] sb_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic                double_issue;
  logic                err_q;

  wb_rr_arbiter u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid0 (wb.req0_valid),
    .valid1 (wb.req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign wb.req0_ready = grant0;
  assign wb.req1_ready = grant1;
  assign hs            = grant0 || grant1;
  assign sel_addr      = grant1 ? wb.req1_addr : wb.req0_addr;
  assign sel_data      = grant1 ? wb.req1_data : wb.req0_data;

  // x0 writes complete the handshake but never raise the write enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ena_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_ena_q <= hs && (sel_addr != '0);
      if (hs) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

  assign wb.wr_ena  = wr_ena_q;
  assign wb.wr_addr = wr_addr_q;
  assign wb.wr_data = wr_data_q;

  decoder_5_to_32 u_set_dec (
    .en     (iss_valid && (iss_addr != '0)),
    .sel    (iss_addr),
    .onehot (set_mask)
  );

  decoder_5_to_32 u_clr_dec (
    .en     (wr_ena_q),
    .sel    (wr_addr_q),
    .onehot (clr_mask)
  );

  // Set after clear so a newly issued producer supersedes the committing one.
  always_comb begin
    sb_d    = (sb_q & ~clr_mask) | set_mask;
    sb_d[0] = 1'b0;
  end

  assign double_issue = |(set_mask & sb_q & ~clr_mask);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sb_q <= sb_d;
      if (double_issue) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy0            = (chk_addr0 != '0) && sb_q[chk_addr0];
  assign busy1            = (chk_addr1 != '0) && sb_q[chk_addr1];
  assign err_double_issue = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter (honours WB_ARB_FIXED_PRIO_EN)
module tb_regfile_wb_arbiter;

  typedef struct {
    logic        ena;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_v;
  logic [4:0]  iss_a;
  logic [4:0]  c0;
  logic [4:0]  c1;
  logic        busy0;
  logic        busy1;
  logic        err;

  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;

  wr_exp_t     exp_q[$];
  logic [31:0] sb_m;
  logic        err_m;
  logic        ptr_m;
  logic        obs_r0, obs_r1;
  int          n_tests = 0;
  int          n_fail  = 0;

  regfile_wb_arbiter_if wb ();

  regfile_wb_arbiter dut (
    .clk              (clk),
    .rst              (rst_n),
    .wb               (wb),
    .iss_valid        (iss_v),
    .iss_addr         (iss_a),
    .chk_addr0        (c0),
    .chk_addr1        (c1),
    .busy0            (busy0),
    .busy1            (busy1),
    .err_double_issue (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    wb.req0_valid = v0;
    wb.req0_addr  = a0;
    wb.req0_data  = d0;
    wb.req1_valid = v1;
    wb.req1_addr  = a1;
    wb.req1_data  = d1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare outputs at negedge, advance the model, then return 1ns past posedge.
  task automatic step();
    wr_exp_t     e;
    logic        er0, er1;
    logic [4:0]  ga;
    logic [31:0] sb_n;
    @(negedge clk);
    check("wr_queue_depth", exp_q.size(), 1);
    e = '{1'b0, 5'd0, 32'd0};
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("wr_ena", wb.wr_ena, e.ena);
    if (e.ena) begin
      check("wr_addr", wb.wr_addr, e.addr);
      check("wr_data", wb.wr_data, e.data);
    end
    check("busy0", busy0, (c0 != 0) && sb_m[c0]);
    check("busy1", busy1, (c1 != 0) && sb_m[c1]);
    check("err_double_issue", err, err_m);
`ifdef WB_ARB_FIXED_PRIO_EN
    er1 = v1;
    er0 = v0 && !v1;
`else
    if (v0 && v1) begin
      er0 = (ptr_m == 1'b0);
      er1 = (ptr_m == 1'b1);
    end else begin
      er0 = v0;
      er1 = v1;
    end
`endif
    obs_r0 = wb.req0_ready;
    obs_r1 = wb.req1_ready;
    check("req0_ready", obs_r0, er0);
    check("req1_ready", obs_r1, er1);
    if (!rst_n) begin
      ptr_m = 1'b0;
      sb_m  = '0;
      err_m = 1'b0;
      exp_q.push_back('{1'b0, 5'd0, 32'd0});
    end else begin
      if (er0 || er1) begin
        ga = er1 ? a1 : a0;
        exp_q.push_back('{(ga != 0), ga, (er1 ? d1 : d0)});
        if (v0 && v1) ptr_m = er0;
      end else begin
        exp_q.push_back('{1'b0, 5'd0, 32'd0});
      end
      sb_n = sb_m;
      if (e.ena) sb_n[e.addr] = 1'b0;
      if (iss_v && iss_a != 0) begin
        if (sb_m[iss_a] && !(e.ena && e.addr == iss_a)) err_m = 1'b1;
        sb_n[iss_a] = 1'b1;
      end
      sb_m = sb_n;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [3:0] seq;
    rst_n = 1'b0;
    v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    iss_v = 0; iss_a = 0; c0 = 0; c1 = 0;
    sb_m = '0; err_m = 1'b0; ptr_m = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back('{1'b0, 5'd0, 32'd0});
    step();
    rst_n = 1'b1;
    step();

    // Single ALU writeback.
    v0 = 1; a0 = 5; d0 = 32'hDEADBEEF;
    step();
    v0 = 0;
    step();
    step();

    // Contested requesters for four cycles.
    v0 = 1; a0 = 1; d0 = 32'h11;
    v1 = 1; a1 = 2; d1 = 32'h22;
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      seq = {seq[2:0], obs_r1};
    end
    v0 = 0; v1 = 0;
    step();
`ifdef WB_ARB_FIXED_PRIO_EN
    check("grant_sequence", {28'd0, seq}, 32'hF);
`else
    check("grant_sequence", {28'd0, seq}, 32'h5);
`endif

    // Pending write on x7 cleared by a load writeback.
    iss_v = 1; iss_a = 7; c0 = 7;
    step();
    iss_v = 0;
    step();
    v1 = 1; a1 = 7; d1 = 32'h77;
    step();
    v1 = 0;
    step();
    step();

    // Write to x0 is swallowed.
    v0 = 1; a0 = 0; d0 = 32'h1234; c0 = 0; c1 = 0;
    step();
    v0 = 0;
    step();
    step();

    // Same-edge issue/commit on x3, then a true double issue.
    iss_v = 1; iss_a = 3; c1 = 3;
    step();
    iss_v = 0;
    v0 = 1; a0 = 3; d0 = 32'h33;
    step();
    v0 = 0;
    iss_v = 1; iss_a = 3;
    step();
    iss_v = 0;
    step();
    iss_v = 1; iss_a = 3;
    step();
    iss_v = 0;
    step();
    step();

    // Reset while a contested handshake is in flight.
    v0 = 1; a0 = 4; d0 = 32'h44;
    v1 = 1; a1 = 6; d1 = 32'h66;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    v0 = 0; v1 = 0;
    step();
    step();

    // Random traffic; a stalled requester holds its request.
    for (int i = 0; i < 80; i++) begin
      if (!(v0 && !obs_r0)) begin
        v0 = $urandom_range(0, 1);
        a0 = 5'($urandom_range(0, 31));
        d0 = $urandom;
      end
      if (!(v1 && !obs_r1)) begin
        v1 = $urandom_range(0, 1);
        a1 = 5'($urandom_range(0, 31));
        d1 = $urandom;
      end
      iss_v = ($urandom_range(0, 3) == 0);
      iss_a = 5'($urandom_range(0, 31));
      c0    = 5'($urandom_range(0, 31));
      c1    = 5'($urandom_range(0, 31));
      step();
    end
    v0 = 0; v1 = 0; iss_v = 0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
